knn_sched: RTL and testbench

Per-center-point sequencer for the KNN grouping engine. It walks NCP center points held in an external CP memory and, for each one, drives the engine through one full run:
- CP pulse,
- a DN-point LP burst read from an external LP memory,
- STAGE_NUM-1 mask rounds.

Each engine result strobe is tagged with its CP index and stage so downstream grouping logic can file the results. It sits between the point-cloud buffers and the KNN engine, and is the only master of the engine's CP/LP/mask inputs.

---
 rtl/knn_sched_if.sv | 48 ++++
 rtl/knn_sched.sv | 184 ++++++++++++++++++
 tb/tb_knn_sched.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_sched_if.sv
// Engine, memory and job-control bundle of the KNN center-point sequencer.
// The master modport is the sequencer side; the slave modport is the engine/memory/host side.
interface knn_sched_if #(
    parameter int DN        = 1024,
    parameter int ADDR_W    = 24,
    parameter int NCP       = 256,
    parameter int STAGE_NUM = 8
);
    localparam int CPW = (NCP > 1) ? $clog2(NCP) : 1;
    localparam int LPW = (DN > 1) ? $clog2(DN) : 1;
    localparam int STW = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;

    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [CPW-1:0]    cp_raddr;
    logic [ADDR_W-1:0] cp_rdata;
    logic [LPW-1:0]    lp_raddr;
    logic [ADDR_W-1:0] lp_rdata;
    logic [ADDR_W-1:0] knn_cp;
    logic              knn_cp_vld;
    logic              knn_cp_ready;
    logic [ADDR_W-1:0] knn_lp;
    logic              knn_lp_vld;
    logic              knn_lp_ready;
    logic              knn_mask_vld;
    logic [STW-1:0]    mask_round;
    logic              knn_output_flag;
    logic              knn_cp_finish;
    logic              res_vld;
    logic [CPW-1:0]    res_cp_idx;
    logic [STW-1:0]    res_stage;

    modport master (
        input  start, cp_rdata, lp_rdata, knn_cp_ready, knn_lp_ready,
               knn_output_flag, knn_cp_finish,
        output busy, done, err, cp_raddr, lp_raddr, knn_cp, knn_cp_vld, knn_lp,
               knn_lp_vld, knn_mask_vld, mask_round, res_vld, res_cp_idx, res_stage
    );

    modport slave (
        output start, cp_rdata, lp_rdata, knn_cp_ready, knn_lp_ready,
               knn_output_flag, knn_cp_finish,
        input  busy, done, err, cp_raddr, lp_raddr, knn_cp, knn_cp_vld, knn_lp,
               knn_lp_vld, knn_mask_vld, mask_round, res_vld, res_cp_idx, res_stage
    );
endinterface

// File: rtl/knn_sched.sv
// knn_sched: walks NCP center points, issuing CP strobe, unstalled DN-point LP burst and mask rounds per CP.
// CP strobe 3 cycles after start, held off by engine ready; KNN_SCHED_WDOG_EN adds a wait-state watchdog.
module knn_sched #(
    parameter int DN        = 1024,
    parameter int ADDR_W    = 24,
    parameter int NCP       = 256,
    parameter int STAGE_NUM = 8,
    parameter int WDOG_CYC  = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    knn_sched_if.master bus
);
    localparam int CPW = (NCP > 1) ? $clog2(NCP) : 1;
    localparam int LPW = (DN > 1) ? $clog2(DN) : 1;
    localparam int STW = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CP_SEND, S_LP_SEND, S_WAIT_OUT, S_MASK_SEND, S_WAIT_FIN
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_cp_vld;
    logic              r_lp_vld;
    logic              r_mask_vld;
    logic [ADDR_W-1:0] r_knn_cp;
    logic [CPW-1:0]    r_cp_idx;
    logic [LPW-1:0]    r_lp_raddr;
    logic [LPW:0]      r_lp_cnt;
    logic [LPW:0]      r_mask_cnt;
    logic [STW-1:0]    r_stage;
    logic [STW-1:0]    r_mask_round;

`ifdef KNN_SCHED_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYC + 1);
    logic              r_err;
    logic [WDW-1:0]    r_wdog;
    logic              w_wdog_run;

    // Counts only while staying in a wait state, so any transition restarts it.
    always_comb begin
        w_wdog_run = 1'b0;
        case (r_state)
            S_CP_SEND:  w_wdog_run = !r_cp_vld;
            S_WAIT_OUT: w_wdog_run = !bus.knn_output_flag;
            S_WAIT_FIN: w_wdog_run = !bus.knn_cp_finish;
            default:    w_wdog_run = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cp_vld     <= 1'b0;
            r_lp_vld     <= 1'b0;
            r_mask_vld   <= 1'b0;
            r_knn_cp     <= '0;
            r_cp_idx     <= '0;
            r_lp_raddr   <= '0;
            r_lp_cnt     <= '0;
            r_mask_cnt   <= '0;
            r_stage      <= '0;
            r_mask_round <= '0;
`ifdef KNN_SCHED_WDOG_EN
            r_err        <= 1'b0;
            r_wdog       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef KNN_SCHED_WDOG_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy   <= 1'b1;
                        r_cp_idx <= '0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_CP_SEND;
                S_CP_SEND: begin
                    r_knn_cp <= bus.cp_rdata;
                    // Strobe cycle presents LP address 0 so data is ready for the burst's first beat.
                    if (r_cp_vld) begin
                        r_cp_vld   <= 1'b0;
                        r_lp_vld   <= 1'b1;
                        r_lp_raddr <= LPW'(1);
                        r_lp_cnt   <= (LPW+1)'(1);
                        r_state    <= S_LP_SEND;
                    end else if (bus.knn_cp_ready && bus.knn_lp_ready) begin
                        r_cp_vld   <= 1'b1;
                        r_lp_raddr <= '0;
                    end
                end
                S_LP_SEND: begin
                    if (r_lp_cnt == (LPW+1)'(DN)) begin
                        r_lp_vld     <= 1'b0;
                        r_stage      <= '0;
                        r_mask_round <= '0;
                        r_state      <= S_WAIT_OUT;
                    end else begin
                        r_lp_cnt   <= r_lp_cnt + (LPW+1)'(1);
                        r_lp_raddr <= r_lp_raddr + LPW'(1);
                    end
                end
                S_WAIT_OUT: begin
                    if (bus.knn_output_flag) begin
                        r_stage <= r_stage + STW'(1);
                        if (r_stage == STW'(STAGE_NUM - 1)) begin
                            r_state <= S_WAIT_FIN;
                        end else begin
                            r_mask_vld <= 1'b1;
                            r_mask_cnt <= (LPW+1)'(DN) >> r_mask_round;
                            r_state    <= S_MASK_SEND;
                        end
                    end
                end
                S_MASK_SEND: begin
                    if (r_mask_cnt == (LPW+1)'(1)) begin
                        r_mask_vld   <= 1'b0;
                        r_mask_round <= r_mask_round + STW'(1);
                        r_state      <= S_WAIT_OUT;
                    end else begin
                        r_mask_cnt <= r_mask_cnt - (LPW+1)'(1);
                    end
                end
                S_WAIT_FIN: begin
                    if (bus.knn_cp_finish) begin
                        if (r_cp_idx == CPW'(NCP - 1)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cp_idx <= r_cp_idx + CPW'(1);
                            r_state  <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef KNN_SCHED_WDOG_EN
            // Placed after the case so an expiry overrides that cycle's transition.
            if (w_wdog_run) begin
                if (r_wdog == WDW'(WDOG_CYC - 1)) begin
                    r_err    <= 1'b1;
                    r_busy   <= 1'b0;
                    r_cp_vld <= 1'b0;
                    r_wdog   <= '0;
                    r_state  <= S_IDLE;
                end else begin
                    r_wdog <= r_wdog + WDW'(1);
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.cp_raddr     = r_cp_idx;
    assign bus.lp_raddr     = r_lp_raddr;
    assign bus.knn_cp       = r_knn_cp;
    assign bus.knn_cp_vld   = r_cp_vld;
    assign bus.knn_lp       = bus.lp_rdata;
    assign bus.knn_lp_vld   = r_lp_vld;
    assign bus.knn_mask_vld = r_mask_vld;
    assign bus.mask_round   = r_mask_round;
    assign bus.res_vld      = bus.knn_output_flag & r_busy;
    assign bus.res_cp_idx   = r_cp_idx;
    assign bus.res_stage    = r_stage;
`ifdef KNN_SCHED_WDOG_EN
    assign bus.err          = r_err;
`else
    assign bus.err          = 1'b0 && (WDOG_CYC > 0);
`endif
endmodule

// File: tb/tb_knn_sched.sv
// Directed bench for knn_sched: small engine model, memory models and negedge monitors feeding per-test checks.
module tb_knn_sched;
    localparam int DN        = 8;
    localparam int ADDR_W    = 24;
    localparam int NCP       = 2;
    localparam int STAGE_NUM = 3;
    localparam int WDOG_CYC  = 16;
`ifdef KNN_SCHED_WDOG_EN
    localparam int STALL_CYC = 10;
`else
    localparam int STALL_CYC = 20;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    knn_sched_if #(.DN(DN), .ADDR_W(ADDR_W), .NCP(NCP), .STAGE_NUM(STAGE_NUM)) bus ();

    knn_sched #(.DN(DN), .ADDR_W(ADDR_W), .NCP(NCP), .STAGE_NUM(STAGE_NUM), .WDOG_CYC(WDOG_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [ADDR_W-1:0] cp_mem [NCP];
    logic [ADDR_W-1:0] lp_mem [DN];

    always @(posedge clk) begin
        bus.cp_rdata <= cp_mem[bus.cp_raddr];
        bus.lp_rdata <= lp_mem[bus.lp_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Engine model: result flag 2 cycles after each LP/mask burst ends, finish 2 cycles after the last flag.
    bit eng_en = 1'b0;
    initial begin : engine
        int fcnt    = 0;
        int fincnt  = 0;
        int nflag   = 0;
        bit prev_lp   = 1'b0;
        bit prev_mask = 1'b0;
        bus.knn_output_flag = 1'b0;
        bus.knn_cp_finish   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.knn_output_flag = 1'b0;
            bus.knn_cp_finish   = 1'b0;
            if (!eng_en) begin
                fcnt = 0; fincnt = 0; nflag = 0;
            end else begin
                if (fcnt > 0) begin
                    fcnt--;
                    if (fcnt == 0) begin
                        bus.knn_output_flag = 1'b1;
                        nflag++;
                        if (nflag == STAGE_NUM) fincnt = 3;
                    end
                end
                if (fincnt > 0) begin
                    fincnt--;
                    if (fincnt == 0) begin
                        bus.knn_cp_finish = 1'b1;
                        nflag = 0;
                    end
                end
                if ((prev_lp && !bus.knn_lp_vld) || (prev_mask && !bus.knn_mask_vld)) fcnt = 2;
            end
            prev_lp   = bus.knn_lp_vld;
            prev_mask = bus.knn_mask_vld;
        end
    end

    // Monitors
    int n_cp_vld = 0, n_cp_long = 0, n_done = 0, n_err = 0;
    int cp_vals[$], cp_cyc[$], lp_vals[$], lp_runs[$], mask_runs[$], mask_dly[$], res_tags[$];
    int lp_run = 0, mask_run = 0, flag_cyc = 0, lp_last = 0, err_cyc = 0;
    bit prev_cp = 1'b0;
    always @(negedge clk) begin
        if (bus.knn_cp_vld) begin
            n_cp_vld++;
            if (prev_cp) n_cp_long++;
            cp_vals.push_back(int'(bus.knn_cp));
            cp_cyc.push_back(cyc);
        end
        prev_cp = bus.knn_cp_vld;
        if (bus.knn_lp_vld) begin
            lp_run++;
            lp_vals.push_back(int'(bus.knn_lp));
            lp_last = cyc;
        end else if (lp_run != 0) begin
            lp_runs.push_back(lp_run);
            lp_run = 0;
        end
        if (bus.knn_mask_vld) begin
            if (mask_run == 0) mask_dly.push_back(cyc - flag_cyc);
            mask_run++;
        end else if (mask_run != 0) begin
            mask_runs.push_back(mask_run);
            mask_run = 0;
        end
        if (bus.knn_output_flag) flag_cyc = cyc;
        if (bus.res_vld) res_tags.push_back(int'(bus.res_cp_idx) * 4 + int'(bus.res_stage));
        if (bus.done) n_done++;
        if (bus.err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        eng_en = 1'b0;
        bus.start = 1'b0;
        bus.knn_cp_ready = 1'b1;
        bus.knn_lp_ready = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_job_end(input int bound, output bit timed_out);
        int b_done, b_err;
        b_done = n_done;
        b_err = n_err;
        timed_out = 1'b1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (n_done != b_done || n_err != b_err) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.knn_cp_ready = 1'b1;
        bus.knn_lp_ready = 1'b1;
        eng_en = 1'b0;
        rst_n = 1'b0;
        tick(2);
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.knn_cp_vld, bus.knn_lp_vld, bus.knn_mask_vld, bus.res_vld} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctl: got %b expected 0", {bus.busy, bus.done, bus.err, bus.knn_cp_vld, bus.knn_lp_vld, bus.knn_mask_vld, bus.res_vld});
        end
        n_checks++;
        if ({bus.knn_cp, bus.cp_raddr, bus.lp_raddr, bus.mask_round, bus.res_cp_idx, bus.res_stage} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got %h expected 0", {bus.knn_cp, bus.cp_raddr, bus.lp_raddr, bus.mask_round, bus.res_cp_idx, bus.res_stage});
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.knn_cp_vld, bus.knn_lp_vld, bus.knn_mask_vld, bus.res_vld} !== 7'b0) begin
            n_errors++;
            $display("FAIL release_ctl: got %b expected 0", {bus.busy, bus.done, bus.err, bus.knn_cp_vld, bus.knn_lp_vld, bus.knn_mask_vld, bus.res_vld});
        end
        pulse_start();
        n_checks++;
        if ({bus.busy, bus.cp_raddr, bus.knn_cp_vld} !== {1'b1, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL start_busy: got busy=%b cp_raddr=%0d cp_vld=%b expected 1,0,0", bus.busy, bus.cp_raddr, bus.knn_cp_vld);
        end
        tick();
        n_checks++;
        if (bus.knn_cp_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL cp_vld_early: got %b expected 0", bus.knn_cp_vld);
        end
        tick();
        n_checks++;
        if ({bus.knn_cp_vld, bus.knn_cp, bus.lp_raddr} !== {1'b1, cp_mem[0], 3'd0}) begin
            n_errors++;
            $display("FAIL cp_strobe: got vld=%b cp=%h lp_raddr=%0d expected 1,%h,0", bus.knn_cp_vld, bus.knn_cp, bus.lp_raddr, cp_mem[0]);
        end
        tick();
        n_checks++;
        if ({bus.knn_cp_vld, bus.knn_lp_vld, bus.lp_raddr, bus.knn_lp} !== {1'b0, 1'b1, 3'd1, lp_mem[0]}) begin
            n_errors++;
            $display("FAIL lp_first_beat: got cpv=%b lpv=%b raddr=%0d lp=%h expected 0,1,1,%h", bus.knn_cp_vld, bus.knn_lp_vld, bus.lp_raddr, bus.knn_lp, lp_mem[0]);
        end
    endtask

    task automatic test_full_job();
        int b_cp, b_cpq, b_lpv, b_lpr, b_mr, b_md, b_res, b_done, b_err, bad;
        bit to;
        int exp_mask[4] = '{8, 4, 8, 4};
        int exp_res[6]  = '{0, 1, 2, 4, 5, 6};
        do_reset();
        eng_en = 1'b1;
        b_cp = n_cp_vld; b_cpq = cp_vals.size(); b_lpv = lp_vals.size(); b_lpr = lp_runs.size();
        b_mr = mask_runs.size(); b_md = mask_dly.size(); b_res = res_tags.size(); b_done = n_done; b_err = n_err;
        pulse_start();
        wait_job_end(1000, to);
        tick(3);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL job_timeout: got timeout=%b expected 0", to); end
        n_checks++;
        if (n_done - b_done !== 1) begin n_errors++; $display("FAIL job_done: got %0d expected 1", n_done - b_done); end
        n_checks++;
        if (n_cp_vld - b_cp !== NCP) begin n_errors++; $display("FAIL job_cp_count: got %0d expected %0d", n_cp_vld - b_cp, NCP); end
        for (int i = 0; i < NCP; i++) begin
            n_checks++;
            if (((b_cpq + i < cp_vals.size()) ? cp_vals[b_cpq + i] : -1) !== int'(cp_mem[i])) begin
                n_errors++;
                $display("FAIL job_cp_value[%0d]: got %h expected %h", i, (b_cpq + i < cp_vals.size()) ? cp_vals[b_cpq + i] : -1, cp_mem[i]);
            end
        end
        n_checks++;
        if (lp_runs.size() - b_lpr !== NCP) begin n_errors++; $display("FAIL job_lp_bursts: got %0d expected %0d", lp_runs.size() - b_lpr, NCP); end
        for (int i = 0; i < NCP; i++) begin
            n_checks++;
            if (((b_lpr + i < lp_runs.size()) ? lp_runs[b_lpr + i] : -1) !== DN) begin
                n_errors++;
                $display("FAIL job_lp_len[%0d]: got %0d expected %0d", i, (b_lpr + i < lp_runs.size()) ? lp_runs[b_lpr + i] : -1, DN);
            end
        end
        bad = 0;
        for (int i = 0; i < NCP * DN; i++)
            if (((b_lpv + i < lp_vals.size()) ? lp_vals[b_lpv + i] : -1) !== int'(lp_mem[i % DN])) bad++;
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL job_lp_data: got %0d wrong beats expected 0", bad); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (((b_mr + i < mask_runs.size()) ? mask_runs[b_mr + i] : -1) !== exp_mask[i]) begin
                n_errors++;
                $display("FAIL job_mask_len[%0d]: got %0d expected %0d", i, (b_mr + i < mask_runs.size()) ? mask_runs[b_mr + i] : -1, exp_mask[i]);
            end
            n_checks++;
            if (((b_md + i < mask_dly.size()) ? mask_dly[b_md + i] : -1) !== 1) begin
                n_errors++;
                $display("FAIL job_mask_delay[%0d]: got %0d expected 1", i, (b_md + i < mask_dly.size()) ? mask_dly[b_md + i] : -1);
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (((b_res + i < res_tags.size()) ? res_tags[b_res + i] : -1) !== exp_res[i]) begin
                n_errors++;
                $display("FAIL job_res_tag[%0d]: got %0d expected %0d", i, (b_res + i < res_tags.size()) ? res_tags[b_res + i] : -1, exp_res[i]);
            end
        end
        n_checks++;
        if (res_tags.size() - b_res !== 6) begin n_errors++; $display("FAIL job_res_count: got %0d expected 6", res_tags.size() - b_res); end
        n_checks++;
        if ({bus.busy, 1'(n_err != b_err)} !== 2'b00) begin n_errors++; $display("FAIL job_idle: got busy=%b errs=%0d expected 0,0", bus.busy, n_err - b_err); end
    endtask

    task automatic test_lp_ready_stall();
        int b_cp, b_cpq, b_long, b_done, rel;
        bit to;
        do_reset();
        eng_en = 1'b1;
        bus.knn_lp_ready = 1'b0;
        b_cp = n_cp_vld; b_cpq = cp_cyc.size(); b_long = n_cp_long; b_done = n_done;
        pulse_start();
        tick(STALL_CYC);
        n_checks++;
        if ({1'(n_cp_vld != b_cp), bus.busy} !== 2'b01) begin
            n_errors++;
            $display("FAIL stall_hold: got cp pulses=%0d busy=%b expected 0,1", n_cp_vld - b_cp, bus.busy);
        end
        bus.knn_lp_ready = 1'b1;
        rel = cyc;
        wait_job_end(1000, to);
        tick(3);
        n_checks++;
        if (((b_cpq < cp_cyc.size()) ? cp_cyc[b_cpq] : -1) !== rel + 1) begin
            n_errors++;
            $display("FAIL stall_release: got cycle %0d expected %0d", (b_cpq < cp_cyc.size()) ? cp_cyc[b_cpq] : -1, rel + 1);
        end
        n_checks++;
        if ({n_cp_vld - b_cp, n_cp_long - b_long, n_done - b_done} !== {32'(NCP), 32'd0, 32'd1}) begin
            n_errors++;
            $display("FAIL stall_pulses: got cp=%0d long=%0d done=%0d expected %0d,0,1", n_cp_vld - b_cp, n_cp_long - b_long, n_done - b_done, NCP);
        end
    endtask

    task automatic test_start_ignored();
        int b_cp, b_cpq, b_res, b_done;
        bit to;
        int exp_res[6] = '{0, 1, 2, 4, 5, 6};
        do_reset();
        eng_en = 1'b1;
        b_cp = n_cp_vld; b_cpq = cp_vals.size(); b_res = res_tags.size(); b_done = n_done;
        pulse_start();
        tick(15);
        pulse_start();
        tick(30);
        pulse_start();
        wait_job_end(1000, to);
        tick(10);
        n_checks++;
        if ({n_done - b_done, n_cp_vld - b_cp} !== {32'd1, 32'(NCP)}) begin
            n_errors++;
            $display("FAIL restart_counts: got done=%0d cp=%0d expected 1,%0d", n_done - b_done, n_cp_vld - b_cp, NCP);
        end
        for (int i = 0; i < NCP; i++) begin
            n_checks++;
            if (((b_cpq + i < cp_vals.size()) ? cp_vals[b_cpq + i] : -1) !== int'(cp_mem[i])) begin
                n_errors++;
                $display("FAIL restart_cp_seq[%0d]: got %h expected %h", i, (b_cpq + i < cp_vals.size()) ? cp_vals[b_cpq + i] : -1, cp_mem[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (((b_res + i < res_tags.size()) ? res_tags[b_res + i] : -1) !== exp_res[i]) begin
                n_errors++;
                $display("FAIL restart_res_tag[%0d]: got %0d expected %0d", i, (b_res + i < res_tags.size()) ? res_tags[b_res + i] : -1, exp_res[i]);
            end
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL restart_idle: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_mask();
        int b_cp, b_done;
        bit found;
        do_reset();
        eng_en = 1'b1;
        b_done = n_done;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.knn_mask_vld === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (found !== 1'b1) begin n_errors++; $display("FAIL mask_reach: got found=%b expected 1", found); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.knn_mask_vld, bus.busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_async: got mask_vld=%b busy=%b expected 0,0", bus.knn_mask_vld, bus.busy);
        end
        eng_en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        b_cp = n_cp_vld;
        tick(30);
        n_checks++;
        if ({bus.busy, bus.knn_mask_vld, bus.knn_lp_vld, 1'(n_cp_vld != b_cp), 1'(n_done != b_done)} !== 5'b0) begin
            n_errors++;
            $display("FAIL rst_idle: got busy=%b mask=%b lp=%b cp=%0d done=%0d expected all 0", bus.busy, bus.knn_mask_vld, bus.knn_lp_vld, n_cp_vld - b_cp, n_done - b_done);
        end
    endtask

    task automatic test_watchdog();
        int b_err, b_done;
        do_reset();
        eng_en = 1'b0;
        b_err = n_err; b_done = n_done;
        pulse_start();
`ifdef KNN_SCHED_WDOG_EN
        begin
            bit to;
            wait_job_end(300, to);
            tick(2);
            n_checks++;
            if (to !== 1'b0) begin n_errors++; $display("FAIL wdog_timeout: got timeout=%b expected 0", to); end
            n_checks++;
            if (err_cyc !== lp_last + 1 + WDOG_CYC) begin
                n_errors++;
                $display("FAIL wdog_cycle: got %0d expected %0d", err_cyc, lp_last + 1 + WDOG_CYC);
            end
            tick(20);
            n_checks++;
            if ({n_err - b_err, n_done - b_done, 31'(bus.busy)} !== {32'd1, 32'd0, 31'd0}) begin
                n_errors++;
                $display("FAIL wdog_abort: got err=%0d done=%0d busy=%b expected 1,0,0", n_err - b_err, n_done - b_done, bus.busy);
            end
        end
`else
        tick(100);
        n_checks++;
        if ({n_err - b_err, n_done - b_done, 31'(bus.busy)} !== {32'd0, 32'd0, 31'd1}) begin
            n_errors++;
            $display("FAIL wait_unbounded: got err=%0d done=%0d busy=%b expected 0,0,1", n_err - b_err, n_done - b_done, bus.busy);
        end
`endif
    endtask

    initial begin
        bus.start = 1'b0;
        bus.knn_cp_ready = 1'b1;
        bus.knn_lp_ready = 1'b1;
        cp_mem[0] = 24'hA1B2C3;
        cp_mem[1] = 24'h0D0E0F;
        for (int i = 0; i < DN; i++) lp_mem[i] = 24'h100000 + 24'(i) * 24'h010101;
        test_reset();
        test_full_job();
        test_lp_ready_stall();
        test_start_ignored();
        test_reset_mid_mask();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "bench timeout");
    end
endmodule
